// File: rtl/seq_shifter.sv
// seq_shifter: handshaked multi-cycle shifter. It applies one single-position
// step per clock, up to 2^AMT_W-1 steps, and holds the result until it is taken.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data, data_step;
  logic [1:0]       op;
  logic [AMT_W-1:0] cnt;
  logic             accept;

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state == IDLE) & ~reset;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sout      = data;

  // One single-position step of the data register, chosen by the captured op
  always_comb begin
    data_step = data;
    unique case (op)
      2'b01:   data_step = {data[WIDTH-2:0], 1'b0};
      2'b10:   data_step = {1'b0, data[WIDTH-1:1]};
      2'b11:   data_step = {data[WIDTH-1], data[WIDTH-1:1]};
      default: data_step = data;
    endcase
  end

  // Next-state logic: pass or zero-amount requests skip SHIFT entirely
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept) state_nxt = (amt == CNT_ZERO || shift == 2'b00) ? DONE : SHIFT;
      SHIFT:
        if (cnt == CNT_ONE) state_nxt = DONE;
      DONE:
        if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Datapath: load on accept, step and count down while shifting, hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      op   <= 2'b00;
      cnt  <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (accept) begin
            data <= in;
            op   <= shift;
            cnt  <= amt;
          end
        SHIFT: begin
          data <= data_step;
          cnt  <= cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: reset, each shift code, pass/zero amount,
// saturation, backpressure, back-to-back handoff and reset mid-operation.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in;
  logic [1:0]  shift;
  logic [3:0]  amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sout;
  logic        busy;

  int checks = 0;
  int failures = 0;

  seq_shifter #(.WIDTH(16), .AMT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in(in), .shift(shift), .amt(amt), .out_valid(out_valid),
    .out_ready(out_ready), .sout(sout), .busy(busy)
  );

  always #5 clk = ~clk;

  // advance one edge; inputs driven and outputs sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue a request in IDLE, return cycles from accept to out_valid and
  // whether busy stayed high on every cycle after the accept
  task automatic issue(input logic [15:0] d, input logic [1:0] s, input logic [3:0] a,
                       output int lat, output bit busy_ok);
    in = d; shift = s; amt = a; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in = 16'hDEAD; shift = 2'b01; amt = 4'hF;   // later changes must be ignored
    lat = 1;
    busy_ok = busy;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in = '0; shift = '0; amt = '0;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    reset = 1'b0;
    #1;
    checks++; if (sout !== 16'h0000) begin failures++; $display("FAIL reset_sout got=%h exp=0000", sout); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_left();
    int lat; bit bok;
    issue(16'hF00F, 2'b01, 4'd4, lat, bok);
    checks++; if (lat !== 5) begin failures++; $display("FAIL left_latency got=%0d exp=5", lat); end
    checks++; if (sout !== 16'h00F0) begin failures++; $display("FAIL left_sout got=%h exp=00f0", sout); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL left_busy got=%b exp=1", bok); end
    retire();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL left_idle busy=%b in_ready=%b exp=0/1", busy, in_ready); end
  endtask

  task automatic test_arith();
    int lat; bit bok;
    issue(16'h8001, 2'b11, 4'd3, lat, bok);
    checks++; if (lat !== 4) begin failures++; $display("FAIL asr_latency got=%0d exp=4", lat); end
    checks++; if (sout !== 16'hF000) begin failures++; $display("FAIL asr_sout got=%h exp=f000", sout); end
    retire();
    issue(16'h8001, 2'b11, 4'd15, lat, bok);
    checks++; if (sout !== 16'hFFFF) begin failures++; $display("FAIL asr_sat1_sout got=%h exp=ffff", sout); end
    retire();
    issue(16'h7FFF, 2'b11, 4'd15, lat, bok);
    checks++; if (sout !== 16'h0000) begin failures++; $display("FAIL asr_sat0_sout got=%h exp=0000", sout); end
    retire();
  endtask

  task automatic test_logical();
    int lat; bit bok;
    issue(16'h8001, 2'b10, 4'd15, lat, bok);
    checks++; if (lat !== 16) begin failures++; $display("FAIL lsr_latency got=%0d exp=16", lat); end
    checks++; if (sout !== 16'h0001) begin failures++; $display("FAIL lsr_sout got=%h exp=0001", sout); end
    retire();
    issue(16'h0F0F, 2'b01, 4'd15, lat, bok);
    checks++; if (sout !== 16'h8000) begin failures++; $display("FAIL lsl15_sout got=%h exp=8000", sout); end
    retire();
  endtask

  task automatic test_pass_zero();
    int lat; bit bok;
    issue(16'h1234, 2'b00, 4'd7, lat, bok);
    checks++; if (lat !== 1) begin failures++; $display("FAIL pass_latency got=%0d exp=1", lat); end
    checks++; if (sout !== 16'h1234) begin failures++; $display("FAIL pass_sout got=%h exp=1234", sout); end
    retire();
    issue(16'h1234, 2'b01, 4'd0, lat, bok);
    checks++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (sout !== 16'h1234) begin failures++; $display("FAIL zero_sout got=%h exp=1234", sout); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat; bit bok; int bad = 0;
    issue(16'hA5C3, 2'b10, 4'd2, lat, bok);   // 0xA5C3 >> 2 = 0x2970
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; in = 16'hFFFF; shift = 2'b01; amt = 4'd3;
      tick();
      checks++;
      if (out_valid !== 1'b1 || sout !== 16'h2970 || in_ready !== 1'b0) begin
        failures++; bad++;
        $display("FAIL backpressure_hold cyc=%0d out_valid=%b sout=%h in_ready=%b exp=1/2970/0", i, out_valid, sout, in_ready);
      end
    end
    in_valid = 1'b0;
    retire();
    checks++; if (out_valid !== 1'b0 || sout !== 16'h2970) begin failures++; $display("FAIL backpressure_retire out_valid=%b sout=%h exp=0/2970", out_valid, sout); end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok; int n = 0;
    issue(16'h00FF, 2'b01, 4'd2, lat, bok);
    checks++; if (sout !== 16'h03FC) begin failures++; $display("FAIL b2b_first_sout got=%h exp=03fc", sout); end
    out_ready = 1'b1; in_valid = 1'b1; in = 16'h8000; shift = 2'b11; amt = 4'd1;
    tick();   // retire edge: new request must not be taken yet
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle out_valid=%b in_ready=%b busy=%b exp=0/1/0", out_valid, in_ready, busy); end
    tick();   // accept edge
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_shift busy=%b out_valid=%b exp=1/0", busy, out_valid); end
    while (!out_valid && n < 20) begin tick(); n++; end
    checks++; if (n !== 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=1", n); end
    checks++; if (sout !== 16'hC000) begin failures++; $display("FAIL b2b_second_sout got=%h exp=c000", sout); end
    retire();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    in = 16'h0001; shift = 2'b01; amt = 4'd8; in_valid = 1'b1;
    tick();   // accept at T, now in T+1
    in_valid = 1'b0;
    tick();   // T+2
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || sout !== 16'h0000 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_mid busy=%b sout=%h out_valid=%b exp=0/0000/0", busy, sout, out_valid); end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL reset_mid_no_result got=%0d exp=0", seen); end
    // a pending result in DONE is also discarded by reset
    in = 16'h1111; shift = 2'b00; amt = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || sout !== 16'h0000 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_done out_valid=%b sout=%h in_ready=%b exp=0/0000/1", out_valid, sout, in_ready); end
  endtask

  initial begin
    test_reset();
    test_left();
    test_arith();
    test_logical();
    test_pass_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
